// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that drains a show-ahead FIFO.
// It pops one word per frame and sends start bit, data LSB first,
// optional even parity, then stop bit. Back-to-back frames have no gap.
// Optional feature macro: FIFO_UART_TX_PARITY_EN (adds the even-parity bit).
module fifo_uart_tx #(
    parameter int Width        = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [Width-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic             tx_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(Width) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(Width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [Width-1:0]  shreg;
    logic [Width-1:0]  shreg_next;
    logic              bit_end;
    logic              launch;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign bit_end    = (baud_cnt == BAUD_LAST);
    assign shreg_next = shreg >> 1;

    // A new frame may start from IDLE or in the very last stop-bit cycle;
    // gated by resetn so no pop can leak out while reset is held.
    assign launch     = resetn && tx_en && !fifo_empty &&
                        ((state == IDLE) || ((state == STOP) && bit_end));
    assign fifo_rd_en = launch;

    // Frame FSM with registered line, busy and done outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            // Raised one cycle early so the registered pulse lands on the final stop cycle.
            frame_done <= (state == STOP) && (baud_cnt == BAUD_PRE);

            if (launch) begin
                // The word is captured here; later changes on fifo_data are ignored.
                shreg    <= fifo_data;
                bit_idx  <= '0;
                baud_cnt <= '0;
                state    <= START;
                tx       <= 1'b0;
                busy     <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_bit <= ^fifo_data;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            state    <= DATA;
                            tx       <= shreg[0];
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            shreg    <= shreg_next;
                            if (bit_idx == IDX_LAST) begin
                                bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                                state   <= PARITY;
                                tx      <= parity_bit;
`else
                                state   <= STOP;
                                tx      <= 1'b1;
`endif
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                tx      <= shreg_next[0];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
`ifdef FIFO_UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            state    <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        // Reaching here on bit_end means no launch: return to idle.
                        if (bit_end) begin
                            baud_cnt <= '0;
                            state    <= IDLE;
                            busy     <= 1'b0;
                            tx       <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        busy     <= 1'b0;
                        tx       <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: FIFO model feeds words, a scoreboard holds
// each popped word and a line monitor decodes tx cycle by cycle against it.
module tb_fifo_uart_tx;

    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = W + 3;
`else
    localparam int NBITS = W + 2;
`endif
    localparam int FLEN = NBITS * CPB;

    logic         clk;
    logic         resetn;
    logic [W-1:0] fifo_data;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic         tx_en;
    logic         tx;
    logic         busy;
    logic         frame_done;

    fifo_uart_tx #(.Width(W), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx_en      (tx_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pops   = 0;
    int frames = 0;
    int b2b    = 0;
    int pop_cyc  = 0;
    int done_cyc = 0;
    int fall_cyc = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endfunction

    task automatic fifo_push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        fifo_refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic exp_bit(input logic [W-1:0] w, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= W) return w[b-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (b == W + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FIFO read side: pop after the edge that saw the strobe.
    initial begin : fifo_model
        logic p;
        logic [W-1:0] w;
        forever begin
            @(posedge clk);
            p = fifo_rd_en;
            #1;
            if (p && fifo_q.size() != 0) begin
                w = fifo_q.pop_front();
                sb.push_back(w);
                pops++;
                fifo_refresh();
            end
        end
    end

    // Line monitor, sampled on the falling edge.
    initial begin : monitor
        bit           in_frame;
        int           k;
        logic [W-1:0] cur;
        logic         busy_prev;
        logic         exp_rd;
        in_frame  = 1'b0;
        k         = 0;
        cur       = '0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_rd_en) pop_cyc = cyc;
            if (frame_done) done_cyc = cyc;
            if (busy_prev && !busy) fall_cyc = cyc;
            if (fifo_rd_en && frame_done) b2b++;
            busy_prev = busy;
            if (!resetn) begin
                in_frame = 1'b0;
                chk("rst_line", 32'(tx), 32'd1);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
                chk("rst_done", 32'(frame_done), 32'd0);
            end else begin
                if (!in_frame && tx == 1'b0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_start", 32'(tx), 32'd1);
                    end else begin
                        cur      = sb.pop_front();
                        in_frame = 1'b1;
                        k        = 0;
                    end
                end
                exp_rd = tx_en && !fifo_empty && (!in_frame || k == FLEN - 1);
                chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
                if (in_frame) begin
                    chk("tx_bit", 32'(tx), 32'(exp_bit(cur, k)));
                    chk("busy_frame", 32'(busy), 32'd1);
                    chk("frame_done", 32'(frame_done), 32'(k == FLEN - 1));
                    k++;
                    if (k == FLEN) begin
                        in_frame = 1'b0;
                        frames++;
                    end
                end else begin
                    chk("busy_idle", 32'(busy), 32'd0);
                    chk("done_idle", 32'(frame_done), 32'd0);
                end
            end
        end
    end

    initial begin : stimulus
        int p0;
        int b0;
        resetn     = 1'b0;
        tx_en      = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = '0;

        // Reset held with a word waiting and permission granted.
        fifo_push(8'hA5);
        repeat (5) begin
            tick();
            chk("rst_hold_tx", 32'(tx), 32'd1);
            chk("rst_hold_busy", 32'(busy), 32'd0);
            chk("rst_hold_rd", 32'(fifo_rd_en), 32'd0);
        end
        tick();
        resetn = 1'b1;
        #1;
        chk("first_pop", 32'(fifo_rd_en), 32'd1);
        repeat (FLEN + 5) tick();
        chk("a5_done_lat", 32'(done_cyc - pop_cyc), 32'(FLEN));
        chk("a5_busy_fall", 32'(fall_cyc - pop_cyc), 32'(FLEN + 1));
        chk("a5_pops", 32'(pops), 32'd1);

        // Back-to-back frames.
        p0 = pops;
        b0 = b2b;
        fifo_push(8'h00);
        fifo_push(8'hFF);
        repeat (2 * FLEN + 6) tick();
        chk("b2b_aligned_pop", 32'(b2b - b0), 32'd1);
        chk("b2b_pops", 32'(pops - p0), 32'd2);
        chk("b2b_line_idle", 32'(tx), 32'd1);
        chk("b2b_busy_idle", 32'(busy), 32'd0);

        // Parity-sensitive words (odd and even bit counts).
        fifo_push(8'h07);
        repeat (FLEN + 4) tick();
        chk("w07_len", 32'(done_cyc - pop_cyc), 32'(FLEN));
        fifo_push(8'h03);
        repeat (FLEN + 4) tick();
        chk("w03_len", 32'(done_cyc - pop_cyc), 32'(FLEN));

        // Permission dropped mid-frame with two words queued.
        p0 = pops;
        fifo_push(8'h3C);
        fifo_push(8'hC3);
        repeat (12) tick();
        chk("txen_in_frame", 32'(busy), 32'd1);
        tx_en = 1'b0;
        repeat (60) tick();
        chk("txen_one_pop", 32'(pops - p0), 32'd1);
        chk("txen_fifo_kept", 32'(fifo_empty), 32'd0);
        chk("txen_idle", 32'(busy), 32'd0);
        tx_en = 1'b1;
        repeat (FLEN + 4) tick();
        chk("txen_resume", 32'(pops - p0), 32'd2);

        // Reset during data bit 3; next word must go out as a full frame.
        p0 = pops;
        fifo_push(8'h5A);
        fifo_push(8'h96);
        for (int i = 0; i < 10 && pops == p0; i++) tick();
        chk("rst3_pop", 32'(pops - p0), 32'd1);
        repeat (17) tick();
        chk("rst3_mid_frame", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rst3_tx_now", 32'(tx), 32'd1);
        chk("rst3_busy_now", 32'(busy), 32'd0);
        repeat (3) tick();
        resetn = 1'b1;
        repeat (FLEN + 6) tick();
        chk("rst3_second_pop", 32'(pops - p0), 32'd2);
        chk("rst3_line_idle", 32'(tx), 32'd1);

        // End-of-run bookkeeping.
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("total_frames", 32'(frames), 32'd8);
        chk("total_pops", 32'(pops), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial UART transmitter that drains the synchronous FIFO from its read side. It pops one word whenever the FIFO is non-empty and the block is free, then serialises the word as a standard asynchronous frame: start bit, data LSB-first, optional parity, stop bit. It connects directly to the FIFO's `rd_en`/`empty`/`data_out` ports and forms the outbound path of the FIFO-buffered serial link.

## Interface
- `Width`, default 8: data bits per frame; must match the FIFO `Width`.
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal minimum is 2.
- `clk`  input  1  system clock; all logic on its rising edge.
- `resetn`  input  1  reset. One clock is used; reset is asynchronous and active-low.
- `fifo_data`  input  Width  FIFO head word. It is show-ahead: valid whenever `fifo_empty`=0.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_rd_en`  output  1  one-cycle pop strobe to the FIFO.
- `tx_en`  input  1  permission to start new frames.
- `tx`  output  1  serial line, idle high, registered.
- `busy`  output  1  high while a frame is in flight, registered.
- `frame_done`  output  1  one-cycle pulse in the last cycle of each stop bit, registered.

## Operation
- States are IDLE, START, DATA, PARITY, and STOP. PARITY exists only with the macro defined.
- **Launch condition:** `tx_en`=1 and `fifo_empty`=0, while in IDLE or in the last cycle of STOP.
  - On launch, `fifo_rd_en`=1 combinationally for that cycle.
  - On the same edge, `fifo_data` is latched into the shift register, the bit counter clears, and the state goes to START.
- `fifo_rd_en` is never 1 when `fifo_empty`=1 or outside a launch cycle. At most one pop happens per frame.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- **DATA:** `Width` bits, LSB first, each held `CLKS_PER_BIT` cycles. The shift register shifts right at each bit boundary.
- **PARITY:** one bit, even parity, equal to the XOR of all `Width` data bits.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles, then either IDLE or, if the launch condition holds, START (back-to-back, zero gap).
- **Counters:**
  - The baud counter is `$clog2(CLKS_PER_BIT)` bits wide, counts 0..`CLKS_PER_BIT`-1, and wraps to 0 at each bit boundary.
  - The bit index is `$clog2(Width)+1` bits wide.
- `busy` = (state != IDLE), registered.
- Dropping `tx_en` mid-frame does not affect the current frame; only the next launch is suppressed.
- A change on `fifo_data` after the pop has no effect on the frame in flight.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `frame_done`=0, `fifo_rd_en`=0, state IDLE, all counters 0, shift register 0.
- **Mid-frame reset:** `tx` goes to 1 and `busy` to 0 immediately (asynchronously). The popped word is discarded and not re-read.
- **Launch latency:** `fifo_rd_en` is high in cycle N; `tx`=0 and `busy`=1 from cycle N+1.
- **Frame length:** (`Width`+2)·`CLKS_PER_BIT` cycles, or (`Width`+3)·`CLKS_PER_BIT` with parity.
- **Stop/done alignment:** `frame_done` is high in the final STOP cycle, coincident with a back-to-back `fifo_rd_en` if one occurs.
- **Back-to-back frames:** the next start bit begins the cycle immediately after the previous stop bit ends, with no idle cycle.
- **After an idle return:** `busy`=0 for at least one cycle before the next launch.

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined: the PARITY state is compiled in, and an even-parity bit is sent between the last data bit and the stop bit.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

## Test plan
All scenarios use `Width`=8 and `CLKS_PER_BIT`=4 unless noted.
- **Reset:** hold `resetn`=0 with `fifo_empty`=0 and `tx_en`=1.
  - Expect `tx`=1, `busy`=0, `fifo_rd_en`=0 throughout.
  - After release, first pop occurs on the first edge.
- **Single word 0xA5:** one word in the FIFO, `tx_en`=1.
  - Expect exactly one `fifo_rd_en` pulse.
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total.
  - `frame_done` pulses at cycle 40; `busy` drops at cycle 41.
- **Back-to-back 0x00 then 0xFF:**
  - Second `fifo_rd_en` coincides with the first `frame_done`.
  - `tx` shows no idle gap: 80 contiguous frame cycles, then the line stays 1.
- **Parity, `FIFO_UART_TX_PARITY_EN` defined, word 0x07:**
  - Parity bit=1 after bit 7.
  - Frame is 44 cycles; word 0x03 gives parity bit=0.
- **`tx_en` deasserted mid-DATA, two words queued:**
  - The current frame completes intact.
  - No further `fifo_rd_en` until `tx_en`=1 again; `fifo_empty` stays 0.
- **Reset asserted during data bit 3:**
  - `tx`=1 and `busy`=0 in the same cycle.
  - After release, the next queued word is sent as a fresh, complete frame.
